snake_block_datapath: RTL
=========================

# snake_block_datapath

Parametrised position-and-raster datapath for a snake head or cell. It holds a head position in screen pixels, loads a start position, and steps that position one block in a commanded direction, with wrap-around or wall detection at the screen edges. On request it scans out every pixel of a BLOCK×BLOCK square at the head position for the VGA plotter. It sits between the game control FSM and the VGA adapter, and supersedes the fixed 2×2, 1-pixel-step datapath.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- X_W, 8, x coordinate width; must satisfy 2^X_W ≥ SCREEN_W
- Y_W, 7, y coordinate width; must satisfy 2^Y_W ≥ SCREEN_H
- BLOCK, 2, block side in pixels, ≥1; also the step size per update
- START_X, 50, head x loaded by ld
- START_Y, 30, head y loaded by ld

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ld  in  1  load head with (START_X, START_Y)
- update  in  1  move head one step in direction dir
- dir  in  2  00 right, 01 left, 10 up (y−), 11 down (y+)
- start  in  1  begin a block scan; accepted only in IDLE
- x  out  X_W  pixel x, valid when pix_valid
- y  out  Y_W  pixel y, valid when pix_valid
- pix_valid  out  1  x/y hold a pixel to plot this cycle
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse with the last pixel of a scan
- hit_wall  out  1  one-cycle pulse when a step is blocked at an edge
- head_x / head_y  out  X_W / Y_W  current head position

## Operation
- Reset: head=(0,0), x=y=0, pix_valid=busy=done=hit_wall=0, pending cleared, FSM to IDLE.
- FSM states:
  - IDLE: start → SCAN, with col=row=0.
  - SCAN: runs BLOCK² cycles, then → IDLE.
- Priority each cycle: reset > ld > update > start.
- ld in any state: load the head. In SCAN, ld also aborts the scan: next cycle is IDLE, pix_valid=busy=0, no done.
- update in IDLE: step applied at the next edge.
- update in SCAN: dir latched into a one-deep pending register. It is applied in the cycle after done. A second update while pending overwrites the pending dir (last wins).
- Step arithmetic, in pixels:
  - right: x+BLOCK
  - left: x−BLOCK
  - up: y−BLOCK
  - down: y+BLOCK
- Legal head range: x∈[0, SCREEN_W−BLOCK], y∈[0, SCREEN_H−BLOCK].
- Compute the step at X_W+1 / Y_W+1 bits to detect overflow and underflow.
- Edge behaviour is set by the configuration macro (see Configuration).
- Scan order is row-major with col fastest: pixel k has col=k mod BLOCK, row=k div BLOCK, and x=head_x+col, y=head_y+row.
- The head position is sampled at scan start and is constant during SCAN, because updates are deferred.

## Timing
- start at edge t → first pixel registered at t+1 (pix_valid=1, busy=1).
- Pixels on consecutive cycles t+1 … t+BLOCK².
- done=1 together with the last pix_valid. busy and pix_valid drop at t+BLOCK²+1.
- start while busy: ignored, with no queueing.
- start in the same cycle as update in IDLE: the step is applied and the scan uses the new head (update precedes start).
- Pending step: applied at the edge after done. hit_wall, if any, pulses then.

## Configuration
- SNAKE_WRAP_EN defined:
  - a step past an edge wraps to the opposite edge: right beyond max → 0; left below 0 → SCREEN_W−BLOCK; likewise for y.
  - hit_wall is tied to 0.
- SNAKE_WRAP_EN undefined:
  - a step past an edge leaves the head unchanged.
  - hit_wall pulses for one cycle.

## Structure
- Package snake_pkg holds:
  - dir encoding localparams (DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN);
  - the FSM state typedef (IDLE, SCAN).
- Sub-module block_scan_counter (parameter BLOCK):
  - inputs clear and enable; outputs col, row and last;
  - instantiated once.

## Test plan
- Load and scan: reset, ld, then start with defaults → pixels (50,30),(51,30),(50,31),(51,31) on 4 consecutive cycles; done with (51,31); busy 0 afterwards.
- Wrap (SNAKE_WRAP_EN): head x=158, update dir=00 → head_x=0. Then dir=01 → head_x=158. Then y=0 with dir=10 → head_y=118.
- Wall (no macro): head (158,30), update dir=00 → head stays (158,30) and hit_wall pulses once.
- Deferred step: update dir=11 during the 2nd scan pixel → head_y unchanged until the cycle after done, then 30→32. No pixel shows y≥32.
- Abort: ld during the 3rd pixel with head (10,10) → next cycle busy=0, no done, head=(50,30).
- Reset mid-scan: reset during SCAN → all outputs 0 and head (0,0) next cycle. A start in the following cycle scans (0,0)…(1,1).

Source files
------------

// File: rtl/snake_block_datapath_pkg.sv
// Shared definitions for the snake block datapath: direction encoding and
// the scan FSM state type.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } snake_state_e;

endpackage

// File: rtl/snake_block_datapath_if.sv
// Control/plot bundle between the game FSM (master) and the snake block
// datapath (slave).
//
// Handshake: ld, update and start are single-cycle requests sampled on every
// rising clock edge; there is no ready. pix_valid qualifies x/y for exactly
// one cycle and the plotter must take the pixel that cycle (no backpressure).
// done and hit_wall are one-cycle pulses. state is a debug view of the FSM.
interface snake_block_datapath_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) ();
  import snake_pkg::*;

  logic           ld;
  logic           update;
  logic [1:0]     dir;
  logic           start;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           pix_valid;
  logic           busy;
  logic           done;
  logic           hit_wall;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  snake_state_e   state;

  modport master (
    output ld, update, dir, start,
    input  x, y, pix_valid, busy, done, hit_wall, head_x, head_y, state
  );

  modport slave (
    input  ld, update, dir, start,
    output x, y, pix_valid, busy, done, hit_wall, head_x, head_y, state
  );

endinterface

// File: rtl/snake_block_datapath_counter.sv
// Column/row counter walking a BLOCK x BLOCK square in row-major order,
// column fastest. last flags the final (BLOCK-1, BLOCK-1) position.
module block_scan_counter #(
  parameter  int BLOCK = 2,
  localparam int CNT_W = (BLOCK > 1) ? $clog2(BLOCK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK - 1);

  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;

  // Advance column every enabled cycle, roll into the next row at the edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (enable) begin
      if (col_q == LAST_IDX) begin
        col_q <= '0;
        row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == LAST_IDX) && (row_q == LAST_IDX);

endmodule

// File: rtl/snake_block_datapath.sv
// Snake head position and block raster datapath.
// Holds the head, loads the start position, steps one block per update
// (deferred while a scan runs) and rasters a BLOCK x BLOCK square for the
// plotter. Edge behaviour: SNAKE_WRAP_EN defined -> wrap to the opposite
// edge; undefined -> block the step and pulse hit_wall.
module snake_block_datapath
  import snake_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int BLOCK    = 2,
  parameter int START_X  = 50,
  parameter int START_Y  = 30
) (
  input logic                  clk,
  input logic                  reset,
  snake_block_datapath_if.slave bus
);

  localparam int CNT_W = (BLOCK > 1) ? $clog2(BLOCK) : 1;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Step arithmetic runs one bit wider so overflow/underflow is visible.
  localparam logic [X_W:0] X_STEP = (X_W + 1)'(BLOCK);
  localparam logic [Y_W:0] Y_STEP = (Y_W + 1)'(BLOCK);
  localparam logic [X_W:0] X_MAX  = (X_W + 1)'(SCREEN_W - BLOCK);
  localparam logic [Y_W:0] Y_MAX  = (Y_W + 1)'(SCREEN_H - BLOCK);

  snake_state_e   state_q;
  logic [X_W-1:0] head_x_q;
  logic [Y_W-1:0] head_y_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           pix_valid_q;
  logic           busy_q;
  logic           done_q;
  logic           hit_wall_q;
  logic           pend_valid_q;
  logic [1:0]     pend_dir_q;

  logic [CNT_W-1:0] col_w;
  logic [CNT_W-1:0] row_w;
  logic             last_w;

  logic [1:0]     step_dir_d;
  logic [X_W:0]   sum_x_d;
  logic [Y_W:0]   sum_y_d;
  logic [X_W-1:0] wrap_x_d;
  logic [Y_W-1:0] wrap_y_d;
  logic           step_blocked_d;
  logic [X_W-1:0] step_x_d;
  logic [Y_W-1:0] step_y_d;

  block_scan_counter #(.BLOCK(BLOCK)) u_scan_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == IDLE) || bus.ld),
    .enable (state_q == SCAN),
    .col    (col_w),
    .row    (row_w),
    .last   (last_w)
  );

  // Candidate next head: a fresh update wins over a pending one (last wins).
  always_comb begin
    step_dir_d     = bus.update ? bus.dir : pend_dir_q;
    sum_x_d        = {1'b0, head_x_q};
    sum_y_d        = {1'b0, head_y_q};
    wrap_x_d       = head_x_q;
    wrap_y_d       = head_y_q;
    step_blocked_d = 1'b0;
    case (step_dir_d)
      DIR_RIGHT: begin
        sum_x_d        = {1'b0, head_x_q} + X_STEP;
        step_blocked_d = (sum_x_d > X_MAX);
        wrap_x_d       = '0;
      end
      DIR_LEFT: begin
        sum_x_d        = {1'b0, head_x_q} - X_STEP;
        step_blocked_d = sum_x_d[X_W];
        wrap_x_d       = X_MAX[X_W-1:0];
      end
      DIR_UP: begin
        sum_y_d        = {1'b0, head_y_q} - Y_STEP;
        step_blocked_d = sum_y_d[Y_W];
        wrap_y_d       = Y_MAX[Y_W-1:0];
      end
      default: begin
        sum_y_d        = {1'b0, head_y_q} + Y_STEP;
        step_blocked_d = (sum_y_d > Y_MAX);
        wrap_y_d       = '0;
      end
    endcase
    step_x_d = sum_x_d[X_W-1:0];
    step_y_d = sum_y_d[Y_W-1:0];
    if (step_blocked_d) begin
      step_x_d = WRAP_EN ? wrap_x_d : head_x_q;
      step_y_d = WRAP_EN ? wrap_y_d : head_y_q;
    end
  end

  // Scan FSM with head register and registered plot outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      head_x_q     <= '0;
      head_y_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_wall_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_RIGHT;
    end else begin
      done_q     <= 1'b0;
      hit_wall_q <= 1'b0;
      if (bus.ld) begin
        // Load overrides everything below it and aborts a running scan.
        head_x_q     <= X_W'(START_X);
        head_y_q     <= Y_W'(START_Y);
        pend_valid_q <= 1'b0;
        state_q      <= IDLE;
        pix_valid_q  <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            if (bus.update || pend_valid_q) begin
              head_x_q     <= step_x_d;
              head_y_q     <= step_y_d;
              pend_valid_q <= 1'b0;
              hit_wall_q   <= !WRAP_EN && step_blocked_d;
            end
            if (bus.start) begin
              state_q <= SCAN;
            end
          end
          SCAN: begin
            x_q         <= head_x_q + X_W'(col_w);
            y_q         <= head_y_q + Y_W'(row_w);
            pix_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= last_w;
            if (last_w) begin
              state_q <= IDLE;
            end
            // Head must stay put while plotting; park the step until done.
            if (bus.update) begin
              pend_valid_q <= 1'b1;
              pend_dir_q   <= bus.dir;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_wall  = hit_wall_q;
  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.state     = state_q;

endmodule
